// File: rtl/serial_word_receiver.sv
// serial_word_receiver
// Collects one serial bit per valid cycle into a BITS-wide word, MSB-first or
// LSB-first as chosen by the first bit of each word. Each completed word goes
// into a one-entry holding register with a valid/ready handshake. If a word
// completes while the holding register is still full, that word is dropped
// and a sticky overrun flag is raised. syncIn discards a partial word so the
// receiver can be realigned to a frame boundary.

module serial_word_receiver #(
  parameter int BITS = 8,
  parameter int CNTW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            serIn,
  input  logic            serValid,
  input  logic            lsbFirst,
  input  logic            syncIn,
  input  logic            outReady,
  input  logic            clearOvr,
  output logic [BITS-1:0] regOut,
  output logic            outValid,
  output logic [CNTW-1:0] bitCount,
  output logic            busy,
  output logic            overrun
);

  typedef enum logic {
    S_IDLE,
    S_RECV
  } state_t;

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BITS - 1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [BITS-1:0]   sr_q, sr_d;
  logic              order_q, order_d;
  logic [BITS-1:0]   hold_q, hold_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;

  logic              first_bit;
  logic              word_order;
  logic [CNTW-1:0]   cnt_base;
  logic [BITS-1:0]   sr_next;
  logic              word_done;
  logic              consume;
  logic              drop;

  // Assembly: shift in each valid bit, track the count and detect the last bit
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    order_d   = order_q;
    word_done = 1'b0;

    first_bit  = (state_q == S_IDLE) || syncIn;
    word_order = first_bit ? lsbFirst : order_q;
    cnt_base   = syncIn ? '0 : cnt_q;
    sr_next    = word_order ? {serIn, sr_q[BITS-1:1]} : {sr_q[BITS-2:0], serIn};

    if (serValid) begin
      sr_d    = sr_next;
      order_d = word_order;
      if (cnt_base == CNT_LAST) begin
        cnt_d     = '0;
        state_d   = S_IDLE;
        word_done = 1'b1;
      end else begin
        cnt_d   = cnt_base + CNT_ONE;
        state_d = S_RECV;
      end
    end else if (syncIn) begin
      cnt_d   = '0;
      state_d = S_IDLE;
    end
  end

  // Holding register and overrun: load, consume or drop the completed word
  always_comb begin
    hold_d  = hold_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    consume = valid_q & outReady;
    drop    = word_done & valid_q & ~outReady;

    if (word_done && !drop) begin
      hold_d  = sr_next;
      valid_d = 1'b1;
    end else if (consume) begin
      valid_d = 1'b0;
    end

    if (drop) begin
      ovr_d = 1'b1;
    end else if (clearOvr) begin
      ovr_d = 1'b0;
    end
  end

  // State register with synchronous reset; reset discards any partial word
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      order_q <= 1'b0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      order_q <= order_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign regOut   = hold_q;
  assign outValid = valid_q;
  assign bitCount = cnt_q;
  assign busy     = (cnt_q != '0);
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_serial_word_receiver.sv
// tb_serial_word_receiver
// Directed bench for serial_word_receiver. A queue-based model of the word
// assembly and holding register is compared against the DUT every cycle, and
// hand-computed literal words pin the model to known answers.

module tb_serial_word_receiver;

  localparam int BITS = 8;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            ser_in;
  logic            ser_valid;
  logic            lsb_first;
  logic            sync_in;
  logic            out_ready;
  logic            clear_ovr;
  logic [BITS-1:0] reg_out;
  logic            out_valid;
  logic [CNTW-1:0] bit_count;
  logic            busy;
  logic            overrun;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  bit              m_bits[$];
  bit              m_order;
  logic [BITS-1:0] m_reg;
  bit              m_valid;
  bit              m_ovr;

  serial_word_receiver #(.BITS(BITS), .CNTW(CNTW)) dut (
    .clk      (clk),
    .reset    (reset),
    .serIn    (ser_in),
    .serValid (ser_valid),
    .lsbFirst (lsb_first),
    .syncIn   (sync_in),
    .outReady (out_ready),
    .clearOvr (clear_ovr),
    .regOut   (reg_out),
    .outValid (out_valid),
    .bitCount (bit_count),
    .busy     (busy),
    .overrun  (overrun)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bits are collected in a queue and the word is built from its bit list
  always @(posedge clk) begin : model
    bit              consume;
    bit              done;
    bit              drop;
    logic [BITS-1:0] w;
    if (reset) begin
      m_bits.delete();
      m_order = 1'b0;
      m_reg   = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      consume = m_valid && out_ready;
      done    = 1'b0;
      w       = '0;
      if (sync_in) m_bits.delete();
      if (ser_valid) begin
        if (m_bits.size() == 0) m_order = lsb_first;
        m_bits.push_back(ser_in);
        if (m_bits.size() == BITS) begin
          for (int i = 0; i < BITS; i++) begin
            if (m_order) w[i] = m_bits[i];
            else         w[BITS-1-i] = m_bits[i];
          end
          done = 1'b1;
          m_bits.delete();
        end
      end
      drop = done && m_valid && !consume;
      if (done && !drop) begin
        m_reg   = w;
        m_valid = 1'b1;
      end else if (consume) begin
        m_valid = 1'b0;
      end
      if (drop) m_ovr = 1'b1;
      else if (clear_ovr) m_ovr = 1'b0;
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check_output("model_regOut",   32'(reg_out),   32'(m_reg));
      check_output("model_outValid", 32'(out_valid), 32'(m_valid));
      check_output("model_bitCount", 32'(bit_count), 32'(m_bits.size()));
      check_output("model_busy",     32'(busy),      32'(m_bits.size() != 0));
      check_output("model_overrun",  32'(overrun),   32'(m_ovr));
    end
  end

  task automatic apply_stimulus(input logic v, input logic b, input logic lsb,
                                input logic sync, input logic rdy, input logic clr);
    reset     = 1'b0;
    ser_valid = v;
    ser_in    = b;
    lsb_first = lsb;
    sync_in   = sync;
    out_ready = rdy;
    clear_ovr = clr;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  // Sends the first nbits of w in wire order (w[7] first when MSB-first, w[0] first when LSB-first)
  task automatic send_word(input logic [BITS-1:0] w, input logic lsb, input logic rdy, input int nbits);
    for (int i = 0; i < nbits; i++)
      apply_stimulus(1'b1, lsb ? w[i] : w[BITS-1-i], lsb, 1'b0, rdy, 1'b0);
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence
  initial begin
    logic [BITS-1:0] seq;
    reset = 1'b1; ser_valid = 1'b0; ser_in = 1'b0; lsb_first = 1'b0;
    sync_in = 1'b0; out_ready = 1'b0; clear_ovr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check_output("reset_regOut",   32'(reg_out),   32'h0);
    check_output("reset_outValid", 32'(out_valid), 32'h0);
    check_output("reset_bitCount", 32'(bit_count), 32'h0);
    check_output("reset_busy",     32'(busy),      32'h0);
    check_output("reset_overrun",  32'(overrun),   32'h0);

    // MSB-first 0,0,1,1,0,1,0,1 -> 8'h35, count runs 1..7 then 0
    $display("[TB] MSB-first word");
    seq = 8'b00110101;
    for (int i = 0; i < BITS; i++) begin
      apply_stimulus(1'b1, seq[BITS-1-i], 1'b0, 1'b0, 1'b1, 1'b0);
      check_output("t1_bitCount", 32'(bit_count), 32'((i + 1) % BITS));
    end
    check_output("t1_regOut",   32'(reg_out),   32'h35);
    check_output("t1_outValid", 32'(out_valid), 32'h1);
    idle(1, 1'b1);
    check_output("t1_outValid_drop", 32'(out_valid), 32'h0);

    // LSB-first with a mid-word toggle of lsbFirst -> 8'hAC
    $display("[TB] LSB-first word");
    for (int i = 0; i < BITS; i++)
      apply_stimulus(1'b1, seq[BITS-1-i], (i == 0), 1'b0, 1'b1, 1'b0);
    check_output("t2_regOut",   32'(reg_out),   32'hAC);
    check_output("t2_outValid", 32'(out_valid), 32'h1);
    idle(1, 1'b1);

    // 3 bits, 5-cycle gap, 5 bits -> 8'hB3
    $display("[TB] gap word");
    seq = 8'hB3;
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, seq[BITS-1-i], 1'b0, 1'b0, 1'b1, 1'b0);
    idle(5, 1'b1);
    check_output("t3_gap_bitCount", 32'(bit_count), 32'h3);
    for (int i = 3; i < BITS; i++) apply_stimulus(1'b1, seq[BITS-1-i], 1'b0, 1'b0, 1'b1, 1'b0);
    check_output("t3_regOut", 32'(reg_out), 32'hB3);
    idle(1, 1'b1);

    // 4 bits, sync carrying bit 1, 7 more bits -> 8'hA5
    $display("[TB] sync realign");
    send_word(8'hFF, 1'b0, 1'b1, 4);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check_output("t4_sync_bitCount", 32'(bit_count), 32'h1);
    seq = 8'hA5;
    for (int i = 1; i < BITS; i++) apply_stimulus(1'b1, seq[BITS-1-i], 1'b0, 1'b0, 1'b1, 1'b0);
    check_output("t4_regOut",   32'(reg_out),   32'hA5);
    check_output("t4_outValid", 32'(out_valid), 32'h1);
    idle(1, 1'b1);

    // Backpressure: second word dropped, overrun sticky, set wins over clear
    $display("[TB] backpressure and overrun");
    send_word(8'h35, 1'b0, 1'b0, BITS);
    check_output("t5_first_regOut",   32'(reg_out), 32'h35);
    check_output("t5_first_overrun",  32'(overrun), 32'h0);
    send_word(8'hFF, 1'b0, 1'b0, BITS);
    check_output("t5_drop_regOut",   32'(reg_out),   32'h35);
    check_output("t5_drop_outValid", 32'(out_valid), 32'h1);
    check_output("t5_drop_overrun",  32'(overrun),   32'h1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_output("t5_clear_overrun", 32'(overrun), 32'h0);
    send_word(8'h00, 1'b0, 1'b0, BITS - 1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_output("t5_setwins_overrun", 32'(overrun), 32'h1);
    check_output("t5_setwins_regOut",  32'(reg_out), 32'h35);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_output("t5_clear2_overrun", 32'(overrun), 32'h0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_output("t5_consume_outValid", 32'(out_valid), 32'h0);
    check_output("t5_consume_regOut",   32'(reg_out),   32'h35);

    // Consume and complete in the same cycle -> 8'h0F, no bubble, no overrun
    $display("[TB] simultaneous consume and complete");
    send_word(8'h35, 1'b0, 1'b0, BITS);
    send_word(8'h0F, 1'b0, 1'b0, BITS - 1);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check_output("t6_regOut",   32'(reg_out),   32'h0F);
    check_output("t6_outValid", 32'(out_valid), 32'h1);
    check_output("t6_overrun",  32'(overrun),   32'h0);
    idle(1, 1'b1);

    // Reset mid-word with a full holding register, then a clean word 8'hCA
    $display("[TB] reset mid-operation");
    send_word(8'h35, 1'b0, 1'b0, BITS);
    send_word(8'hCA, 1'b0, 1'b0, 5);
    reset = 1'b1; ser_valid = 1'b0; out_ready = 1'b0; sync_in = 1'b0; clear_ovr = 1'b0;
    @(negedge clk);
    check_output("t7_reset_regOut",   32'(reg_out),   32'h0);
    check_output("t7_reset_outValid", 32'(out_valid), 32'h0);
    check_output("t7_reset_bitCount", 32'(bit_count), 32'h0);
    check_output("t7_reset_busy",     32'(busy),      32'h0);
    check_output("t7_reset_overrun",  32'(overrun),   32'h0);
    send_word(8'hCA, 1'b0, 1'b1, BITS);
    check_output("t7_regOut",   32'(reg_out),   32'hCA);
    check_output("t7_outValid", 32'(out_valid), 32'h1);
    idle(2, 1'b1);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
- Serial-in, parallel-out receiver. It is the receiving end of the serial bit stream produced by the team's universal shift register, or by any shifter driving one bit per cycle.
- Assembles BITS serial bits into a word, MSB-first or LSB-first per word.
- Presents each word through a one-entry holding register with a valid/ready handshake.
- Keeps a sticky overrun flag and a frame-sync input for word alignment.

Parameters:
- BITS, 8, word width and bits per frame (minimum 2).
- CNTW, 4, width of the bit counter; must satisfy 2^CNTW > BITS.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- serIn  input  1  serial data bit
- serValid  input  1  serIn is valid this cycle
- lsbFirst  input  1  bit order for the word; sampled only on the first bit of each word
- syncIn  input  1  frame realign; discards any partial word
- outReady  input  1  consumer accepts regOut this cycle
- clearOvr  input  1  clears the overrun flag
- regOut  output  BITS  received word (holding register)
- outValid  output  1  regOut holds an unconsumed word
- bitCount  output  CNTW  bits collected in the current partial word
- busy  output  1  partial word in progress (bitCount != 0)
- overrun  output  1  sticky: a completed word was dropped

Behaviour:
- Reset (synchronous, active-high, top priority):
  - regOut=0, outValid=0, bitCount=0, busy=0, overrun=0.
  - Shift register and latched order bit also cleared.
  - Reset mid-word discards the partial word.
- Assembly FSM, two states:
  - IDLE (bitCount=0) and RECV (1..BITS-1).
  - IDLE->RECV on serValid. RECV->IDLE on the BITS-th bit or on syncIn.
- First bit (IDLE, serValid=1): latch lsbFirst as the word order; later changes to lsbFirst mid-word are ignored.
- MSB-first shifting: sr <= {sr[BITS-2:0], serIn}. The first bit lands at bit BITS-1 of the final word.
- LSB-first shifting: sr <= {serIn, sr[BITS-1:1]}. The first bit lands at bit 0.
- serValid=0: shift register and counter hold; gaps of any length are allowed.
- syncIn=1:
  - bitCount forced to 0 and the partial word discarded.
  - If serValid=1 in the same cycle, that bit is taken as the first bit of a new word (bitCount=1 next cycle) and lsbFirst is sampled.
  - syncIn never affects regOut, outValid or overrun.
- Word completion: the cycle the BITS-th bit is sampled, the assembled word (including that bit) is the completed word, and bitCount returns to 0.
- Holding register:
  - If empty, or if outValid&outReady this cycle, the completed word is loaded. regOut and outValid=1 are visible the next cycle (latency 1 cycle from the last bit).
  - Simultaneous consume and complete: new word loaded, outValid stays 1, no bubble.
  - Consume without completion: outValid=0 next cycle; regOut keeps its last value.
  - Full and not consumed when a word completes: the new word is dropped, regOut is unchanged, and overrun=1 next cycle.
- Handshake: regOut and outValid are stable while outValid=1 and outReady=0. A transfer occurs on the edge where outValid&outReady=1. outReady while outValid=0 has no effect.
- Overrun:
  - Sticky; cleared only by clearOvr or reset.
  - If clearOvr coincides with a new drop, overrun stays 1 (set wins).
- Back-to-back words: continuous serValid gives one word per BITS cycles with no lost bits. The counter wraps BITS-1 -> 0 directly.
- busy = (bitCount != 0), combinational from the registered count.

Test Plan:
- Reset, then MSB-first: lsbFirst=1'b0, serValid=1, bits 0,0,1,1,0,1,0,1 on consecutive cycles, outReady=1 -> one cycle after the 8th bit, regOut=8'h35 and outValid=1 for exactly one cycle; bitCount counts 1..7 then 0.
- LSB-first: lsbFirst=1'b1 on the first bit (toggled to 0 mid-word), same bit sequence 0,0,1,1,0,1,0,1 -> regOut=8'hAC. The mid-word toggle is ignored.
- Gaps and sync:
  - Send 3 bits, hold serValid=0 for 5 cycles, then 5 more bits -> a single word, correctly assembled.
  - Separately, send 4 bits, pulse syncIn with serValid=1 carrying bit 1, then 7 more bits -> bitCount=1 after the sync, and the word reflects only the post-sync 8 bits.
- Backpressure/overrun:
  - outReady=0 and two full words sent (8'h35 then 8'hFF) -> regOut stays 8'h35, outValid=1, overrun=1 after the second word.
  - clearOvr -> overrun=0.
  - outReady=1 -> outValid=0 next cycle.
- Simultaneous consume and complete: the final bit of word 2 (8'h0F) is sampled in the same cycle outValid&outReady=1 for word 1 -> next cycle regOut=8'h0F, outValid=1, overrun=0.
- Reset mid-operation:
  - Assert reset after 5 bits with outValid=1 -> next cycle all outputs 0.
  - The next 8 bits form a clean new word.
